frame_ctrl: RTL
===============

# frame_ctrl

Frame sequencer for the serial register-access link. It watches the byte strobe from the UART receiver and frames the 3-byte address/data0/data1 protocol. On read frames it samples the register bank's read byte and queues it to the UART transmitter; on write frames it returns an ACK byte. On an inter-byte timeout it resynchronises the register decoder through a reset pulse.

## Interface
- TIMEOUT_CYC, 16'd20000: inter-byte gap, in clk cycles, that aborts a partial frame.
- RD_LAT, 3: cycles from a byte's `rx_ok` falling edge to sampling `rd_data`.
- ACK_BYTE, 8'hA5: byte transmitted after a completed write frame.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte; stable while `rx_ok` is high.
- rx_ok  input  1  receiver byte strobe; high for ≥1 cycle per byte.
- rd_data  input  8  register-bank read byte (the decoder's `data_out`).
- tx_busy  input  1  UART transmitter busy.
- tx_start  output  1  one-cycle transmit request.
- tx_data  output  8  byte to transmit; valid from the `tx_start` cycle and held until the next start.
- dec_rst_n  output  1  active-low resync reset to the register decoder.
- frame_active  output  1  high while the FSM is in ST_D0 or ST_D1.
- err_cnt  output  8  count of timeouts; saturates at 255.
- tx_ovf  output  1  sticky flag: a queued byte was overwritten before it was sent.

## Operation
- Edge detect: `rx_sr <= {rx_sr[0], rx_ok}`. The core acts on `rise` (`rx_sr==2'b01`) and `fall` (`rx_sr==2'b10`). The decoder uses the same edges, so both blocks stay aligned.
- The byte FSM has four states: ST_ADDR, ST_D0, ST_D1, ST_RSYNC.
- ST_ADDR:
  - On `rise`, latch `mode = rx_data[7]` (1 = read).
  - On `fall`, go to ST_D0. If `mode`=1, arm the sample counter.
- ST_D0: on `fall`, go to ST_D1. If `mode`=1, arm the sample counter.
- ST_D1: on `fall`, go to ST_ADDR. If `mode`=0, queue ACK_BYTE. A read frame's third byte is a dummy and causes no transmission.
- Gap timer (16 bit), active in ST_D0 and ST_D1:
  - Cleared on `rise` and held at 0 while `rx_sr[0]`=1.
  - Otherwise increments each cycle.
  - When it reaches TIMEOUT_CYC-1: go to ST_RSYNC, increment `err_cnt` (saturating), cancel any armed sample.
- ST_RSYNC:
  - `dec_rst_n`=0 for exactly 2 cycles, then return to ST_ADDR with the timer cleared.
  - All `rise`/`fall` events during ST_RSYNC are ignored.
- Sample counter:
  - Loaded with RD_LAT-1 when armed.
  - Decrements each cycle; at 0, queue `rd_data` for one cycle.
  - Re-arming while counting restarts the count.
- TX queue: one pending register plus a valid bit.
  - A queue request while valid=1 and no start this cycle overwrites the pending byte and sets `tx_ovf`.
  - Start condition: valid=1, `tx_busy`=0, and `tx_start` was not asserted last cycle (guard for the transmitter's busy latency). On start: `tx_start`=1, `tx_data`=pending, valid cleared.
  - A queue request in the same cycle as a start loads the pending register and sets valid, with no overflow.

## Timing
- Reset values: `tx_start`=0, `tx_data`=8'h00, `dec_rst_n`=1, `frame_active`=0, `err_cnt`=0, `tx_ovf`=0. The FSM resets to ST_ADDR; timer, sample counter and pending valid reset to 0.
- Reset asserted mid-frame or mid-RSYNC aborts immediately. The queued byte is lost and `dec_rst_n` returns to 1 asynchronously.
- `rise`/`fall` are seen 2 cycles after the `rx_ok` transition.
- Read byte sample: RD_LAT cycles after `fall` is decoded.
- `tx_start`: earliest 1 cycle after queueing when `tx_busy`=0. It stays pending for as long as `tx_busy`=1.
- Minimum spacing between `tx_start` pulses: 2 cycles.
- Timeout is measured from the cycle `rx_sr[0]` falls. Exactly TIMEOUT_CYC idle cycles trigger ST_RSYNC. A `rise` on the last idle cycle wins over the timeout.
- `frame_active` is registered and changes 1 cycle after the FSM state.

## Test plan
- Write frame 8'h00, 8'h12, 8'h34 (`tx_busy`=0) -> one `tx_start`, `tx_data`=8'hA5 one cycle after the third `fall`; `err_cnt`=0; FSM ends in ST_ADDR.
- Read frame 8'h82, 8'hFF, 8'hFF, with `rd_data`=8'hC3 after the first byte and 8'h50 after the second -> two `tx_start` pulses with `tx_data` 8'hC3 then 8'h50; no ACK.
- TIMEOUT_CYC=100: send 8'h00 and 8'h11, then idle 100 cycles -> `dec_rst_n` low exactly 2 cycles, `err_cnt`=1, `frame_active`=0. Next frame 8'h01, 8'h22, 8'h33 -> ACK sent.
- Hold `tx_busy`=1 across two read samples (8'hAA then 8'hBB) -> `tx_ovf`=1. After `tx_busy` falls, a single `tx_start` with 8'hBB.
- Force 260 timeouts -> `err_cnt` saturates at 8'hFF.
- Assert `rst` low mid-read while a byte is pending -> all outputs return to reset values; no `tx_start` after release.

Source files
------------

// File: rtl/frame_ctrl.sv
// frame_ctrl: frames 3-byte rx stream (rx_data/rx_ok), samples rd_data on reads, queues tx_start/tx_data, resyncs decoder via dec_rst_n on timeout, reports err_cnt/tx_ovf/frame_active
module frame_ctrl #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd20000,
  parameter logic [7:0]  RD_LAT      = 8'd3,
  parameter logic [7:0]  ACK_BYTE    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ok,
  input  logic [7:0] rd_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       dec_rst_n,
  output logic       frame_active,
  output logic [7:0] err_cnt,
  output logic       tx_ovf
);
  typedef enum logic [1:0] {ST_ADDR, ST_D0, ST_D1, ST_RSYNC} state_t;
  state_t state, state_d;
  logic [1:0] rx_sr;
  logic [15:0] timer;
  logic [7:0] s_cnt, pend, last, q_byte;
  logic mode, r_cnt, s_act, valid, start_q;
  logic rise, fall, in_frame, tout, arm, ack, samp, q_req;
  logic unused;
  assign unused = ^rx_data[6:0];
  always_comb begin
    rise = rx_sr == 2'b01;
    fall = rx_sr == 2'b10;
    in_frame = state == ST_D0 || state == ST_D1;
    tout = in_frame && !rx_sr[0] && timer == TIMEOUT_CYC - 16'd1;
    samp = s_act && s_cnt == 8'd0;
    state_d = state;
    arm = 1'b0;
    ack = 1'b0;
    case (state)
      ST_ADDR: if (fall) begin
        state_d = ST_D0;
        arm = mode;
      end
      ST_D0: if (tout) state_d = ST_RSYNC;
      else if (fall) begin
        state_d = ST_D1;
        arm = mode;
      end
      ST_D1: if (tout) state_d = ST_RSYNC;
      else if (fall) begin
        state_d = ST_ADDR;
        ack = !mode;
      end
      ST_RSYNC: state_d = r_cnt ? ST_ADDR : ST_RSYNC;
    endcase
    q_req = samp || ack;
    q_byte = samp ? rd_data : ACK_BYTE;
    tx_start = valid && !tx_busy && !start_q;
    tx_data = tx_start ? pend : last;
    dec_rst_n = state != ST_RSYNC;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_ADDR;
      rx_sr <= '0;
      timer <= '0;
      s_cnt <= '0;
      pend <= '0;
      last <= '0;
      mode <= 1'b0;
      r_cnt <= 1'b0;
      s_act <= 1'b0;
      valid <= 1'b0;
      start_q <= 1'b0;
      frame_active <= 1'b0;
      err_cnt <= '0;
      tx_ovf <= 1'b0;
    end else begin
      rx_sr <= {rx_sr[0], rx_ok};
      state <= state_d;
      if (state == ST_ADDR && rise) mode <= rx_data[7];
      r_cnt <= state == ST_RSYNC && !r_cnt;
      // the fall cycle that leaves ST_ADDR already counts as the first idle cycle
      timer <= (rx_sr[0] || tout || state == ST_RSYNC || (state == ST_ADDR && !fall)) ? '0 : timer + 16'd1;
      if (tout) s_act <= 1'b0;
      else if (arm) begin
        s_act <= 1'b1;
        s_cnt <= RD_LAT - 8'd1;
      end else if (s_act) begin
        s_act <= s_cnt != 8'd0;
        s_cnt <= s_cnt - 8'd1;
      end
      if (tout && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      frame_active <= in_frame;
      start_q <= tx_start;
      if (tx_start) last <= pend;
      if (q_req) pend <= q_byte;
      valid <= q_req || (valid && !tx_start);
      if (q_req && valid && !tx_start) tx_ovf <= 1'b1;
    end
  end
endmodule
